poseidon_input_packer: RTL and testbench
========================================

Name: poseidon_input_packer

Overview:
- Upstream feeder of the Poseidon top-level stage.
- Packs a narrow host AXI-Stream (64-bit beats, little-endian beat order) into 256-bit field-element words and drives the Poseidon valid/ready/last/payload input interface.
- Zero-pads a message's final partial element.
- Flags any element whose bit 255 is set, since the Poseidon stage only consumes bits [254:0].

Parameters:
- IN_W, 64, input beat width in bits; must divide OUT_W.
- OUT_W, 256, output element width in bits.
- BEATS, OUT_W/IN_W (4), derived number of beats per element; not overridable.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_last  in  1  last beat of message.
- s_data  in  IN_W  input beat.
- m_valid  out  1  element valid; drives io_input_valid.
- m_ready  in  1  element ready; driven by io_input_ready.
- m_last  out  1  last element of message; drives io_input_last.
- m_payload  out  OUT_W  packed element; drives io_input_payload.
- err_msb  out  1  sticky flag: some element was emitted with payload[255]=1.
- err_clr  in  1  synchronous clear for err_msb.
- elem_cnt  out  16  count of elements emitted in the current message; wraps at 2^16.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - beat counter, accumulator, acc_full, acc_last;
  - m_valid=0, m_last=0, m_payload=0;
  - err_msb=0, elem_cnt=0.
- Reset mid-element or mid-message discards all partial data. No output appears until new beats arrive.
- Beat transfer occurs when s_valid && s_ready.
  - Beat k (k = beat counter, 0..BEATS-1) is written into accumulator bits [k*IN_W +: IN_W].
- An element completes on a transfer where k==BEATS-1 or s_last==1.
  - Unwritten upper slices are zero. The accumulator slices are cleared when the next element starts.
  - The beat counter returns to 0.
- Completion routing:
  - If the output register is free or draining (!m_valid || m_ready), the completed element loads m_payload/m_last on the next edge. Latency is 1 cycle from the completing beat to m_valid.
  - Otherwise the element is held in the accumulator, with acc_full=1 and acc_last=s_last.
- s_ready = !acc_full. It is registered-state only and never depends on s_valid or s_last combinationally.
- While acc_full=1: when !m_valid || m_ready, the accumulator moves to the output register and acc_full clears. s_ready rises the following cycle.
- Output handshake (AXI rules):
  - m_valid, once high, stays high and m_payload/m_last stay stable until m_ready.
  - m_valid drops after the handshake unless a new element loads in the same edge.
  - Sustained throughput is 1 element per BEATS cycles with no bubbles when m_ready=1.
- err_msb:
  - Set on an output handshake with m_payload[255]=1. The payload is still forwarded unmodified.
  - err_clr=1 clears it. If set and clear occur in the same cycle, set wins.
- elem_cnt increments on each output handshake. A handshake with m_last=1 sets it to 0 instead.
- s_last with k==0 produces a single element holding one beat plus zeros. Empty messages are impossible by protocol.
- s_valid while s_ready=0 is ignored. Inputs do not need to be held stable (standard AXI assumes they are).

Decomposition:
- Shared package poseidon_stream_pkg holds:
  - IN_W/OUT_W/BEATS constants;
  - element typedef (logic [255:0]);
  - beat typedef;
  - FIELD_MSB=255 constant.
- One natural sub-module: poseidon_elem_reg. It is the single-entry output register with valid/ready/last hold logic, reusable at the Poseidon output side.
- Packer counter and accumulator remain in the top module.

Test Plan:
- Full element, m_ready=1: 4 beats 0x...01, 0x...02, 0x...03, 0x...04 (last on beat 4) -> m_payload = {04,03,02,01} concatenated (beat 0 in [63:0]); m_valid 1 cycle after the 4th beat; m_last=1; elem_cnt returns to 0.
- Partial element: 2 beats 0xAAAA, 0xBBBB with s_last on beat 2 -> m_payload[127:0]={0xBBBB,0xAAAA}, [255:128]=0, m_last=1; the next message's first element carries no stale data.
- Backpressure: m_ready=0 while 12 beats stream in -> first element in the output register, second in the accumulator, s_ready=0 after the 8th beat; no beat lost. Release m_ready -> three elements in order, with m_payload stable while stalled.
- MSB flag: element with beat 3 = 0x8000_0000_0000_0000 -> payload[255]=1 forwarded, err_msb=1 after the handshake. err_clr pulse -> 0. err_clr coincident with a new violation -> stays 1.
- Multi-element message: 3 elements with last only on the 3rd -> m_last=0,0,1; elem_cnt 1,2,0.
- Reset mid-element: 2 beats accepted, reset low for 1 cycle -> all outputs 0. A fresh 4-beat message then produces exactly one element containing only the new beats.

Source files
------------

// File: rtl/poseidon_stream_pkg.sv
// Shared widths and types for the Poseidon input stream path.
// The field element is 256 bits wide; only bits [254:0] are meaningful downstream.
package poseidon_stream_pkg;

   localparam int IN_W      = 64;
   localparam int OUT_W     = 256;
   localparam int BEATS     = OUT_W / IN_W;
   localparam int FIELD_MSB = 255;

   typedef logic [OUT_W-1:0] elem_t;
   typedef logic [IN_W-1:0]  beat_t;

endpackage

// File: rtl/poseidon_elem_reg.sv
// Single-entry output register with valid/ready/last hold logic.
// Latency 1 cycle; in_rdy = !out_vld || out_rdy, so it streams one element per cycle.
module poseidon_elem_reg #(
   parameter int W = 256
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic         in_last,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic         out_last,
   output logic [W-1:0] out_dat
);

   logic         vld_q, vld_d;
   logic         last_q, last_d;
   logic [W-1:0] dat_q, dat_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q  <= 1'b0;
         last_q <= 1'b0;
         dat_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         last_q <= last_d;
         dat_q  <= dat_d;
      end
   end

   always_comb begin
      in_rdy = !vld_q || out_rdy;
      vld_d  = vld_q;
      last_d = last_q;
      dat_d  = dat_q;
      if (in_vld && in_rdy) begin
         vld_d  = 1'b1;
         last_d = in_last;
         dat_d  = in_dat;
      end else if (out_rdy) begin
         vld_d  = 1'b0;
      end
   end

   assign out_vld  = vld_q;
   assign out_last = last_q;
   assign out_dat  = dat_q;

endmodule

// File: rtl/poseidon_input_packer.sv
// Packs IN_W-bit stream beats into OUT_W-bit field elements for the Poseidon stage.
// Latency 1 cycle from completing beat to m_valid; s_ready drops only when a second element is parked.
module poseidon_input_packer #(
   parameter int IN_W  = 64,
   parameter int OUT_W = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             s_last,
   input  logic [IN_W-1:0]  s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic [OUT_W-1:0] m_payload,
   output logic             err_msb,
   input  logic             err_clr,
   output logic [15:0]      elem_cnt
);

   import poseidon_stream_pkg::*;

   localparam int BEATS = OUT_W / IN_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic             acc_full_q, acc_full_d;
   logic             acc_last_q, acc_last_d;
   logic             err_msb_q, err_msb_d;
   logic [15:0]      elem_cnt_q, elem_cnt_d;

   logic [OUT_W-1:0] elem_new;
   logic             beat_fire;
   logic             beat_done;
   logic             ld_vld;
   logic             ld_rdy;
   logic             ld_last;
   logic [OUT_W-1:0] ld_dat;
   logic             out_hs;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt_q <= '0;
         acc_q      <= '0;
         acc_full_q <= 1'b0;
         acc_last_q <= 1'b0;
         err_msb_q  <= 1'b0;
         elem_cnt_q <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         acc_q      <= acc_d;
         acc_full_q <= acc_full_d;
         acc_last_q <= acc_last_d;
         err_msb_q  <= err_msb_d;
         elem_cnt_q <= elem_cnt_d;
      end
   end

   assign s_ready = !acc_full_q;

   // Beat 0 starts a fresh element, so older slices are zeroed before the write.
   always_comb begin
      elem_new = (beat_cnt_q == '0) ? '0 : acc_q;
      elem_new[beat_cnt_q*IN_W +: IN_W] = s_data;
   end

   always_comb begin
      beat_fire = s_valid && s_ready;
      beat_done = beat_fire && ((beat_cnt_q == CNT_W'(BEATS-1)) || s_last);
      ld_vld    = acc_full_q || beat_done;
      ld_last   = acc_full_q ? acc_last_q : s_last;
      ld_dat    = acc_full_q ? acc_q : elem_new;
   end

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      acc_d      = acc_q;
      acc_full_d = acc_full_q;
      acc_last_d = acc_last_q;
      if (beat_fire) begin
         acc_d      = elem_new;
         beat_cnt_d = beat_done ? '0 : beat_cnt_q + 1'b1;
      end
      // A parked element has priority; no beat can fire while it is held.
      if (acc_full_q) begin
         if (ld_rdy) begin
            acc_full_d = 1'b0;
         end
      end else if (beat_done && !ld_rdy) begin
         acc_full_d = 1'b1;
         acc_last_d = s_last;
      end
   end

   poseidon_elem_reg #(
      .W (OUT_W)
   ) u_out_reg (
      .clk      (clk),
      .reset    (reset),
      .in_vld   (ld_vld),
      .in_rdy   (ld_rdy),
      .in_last  (ld_last),
      .in_dat   (ld_dat),
      .out_vld  (m_valid),
      .out_rdy  (m_ready),
      .out_last (m_last),
      .out_dat  (m_payload)
   );

   always_comb begin
      out_hs     = m_valid && m_ready;
      err_msb_d  = err_msb_q;
      elem_cnt_d = elem_cnt_q;
      if (out_hs && m_payload[FIELD_MSB]) begin
         err_msb_d = 1'b1;
      end else if (err_clr) begin
         err_msb_d = 1'b0;
      end
      if (out_hs) begin
         elem_cnt_d = m_last ? 16'd0 : elem_cnt_q + 16'd1;
      end
   end

   assign err_msb  = err_msb_q;
   assign elem_cnt = elem_cnt_q;

endmodule

// File: tb/tb_poseidon_input_packer.sv
// Directed bench for poseidon_input_packer: one task per scenario, inline checks.
module tb_poseidon_input_packer;

   logic         clk = 1'b0;
   logic         reset;
   logic         s_valid;
   logic         s_ready;
   logic         s_last;
   logic [63:0]  s_data;
   logic         m_valid;
   logic         m_ready;
   logic         m_last;
   logic [255:0] m_payload;
   logic         err_msb;
   logic         err_clr;
   logic [15:0]  elem_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   poseidon_input_packer dut (
      .clk       (clk),
      .reset     (reset),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_last    (s_last),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .m_payload (m_payload),
      .err_msb   (err_msb),
      .err_clr   (err_clr),
      .elem_cnt  (elem_cnt)
   );

   // Presents one beat and returns #1 after the edge that accepted it.
   task automatic send_beat(input logic [63:0] d, input logic l);
      bit done = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (s_ready) begin
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL send_beat_timeout: beat %h not accepted, s_ready=%b", d, s_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (m_valid !== 1'b0)     begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
      total++; if (m_last !== 1'b0)      begin bad++; $display("FAIL rst_m_last: got %b want 0", m_last); end
      total++; if (m_payload !== 256'h0) begin bad++; $display("FAIL rst_payload: got %h want 0", m_payload); end
      total++; if (err_msb !== 1'b0)     begin bad++; $display("FAIL rst_err_msb: got %b want 0", err_msb); end
      total++; if (elem_cnt !== 16'd0)   begin bad++; $display("FAIL rst_elem_cnt: got %0d want 0", elem_cnt); end
      total++; if (s_ready !== 1'b1)     begin bad++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_element();
      logic [255:0] exp;
      exp = {64'h4, 64'h3, 64'h2, 64'h1};
      m_ready = 1'b1;
      send_beat(64'h1, 1'b0);
      send_beat(64'h2, 1'b0);
      send_beat(64'h3, 1'b0);
      send_beat(64'h4, 1'b1);
      total++; if (m_valid !== 1'b1)  begin bad++; $display("FAIL full_latency: m_valid got %b want 1", m_valid); end
      total++; if (m_payload !== exp) begin bad++; $display("FAIL full_payload: got %h want %h", m_payload, exp); end
      total++; if (m_last !== 1'b1)   begin bad++; $display("FAIL full_last: got %b want 1", m_last); end
      @(posedge clk); #1;
      total++; if (m_valid !== 1'b0)  begin bad++; $display("FAIL full_drop: m_valid got %b want 0", m_valid); end
      total++; if (elem_cnt !== 16'd0) begin bad++; $display("FAIL full_cnt: got %0d want 0", elem_cnt); end
   endtask

   task automatic test_partial_element();
      logic [255:0] exp;
      exp = {128'h0, 64'hBBBB, 64'hAAAA};
      m_ready = 1'b1;
      send_beat(64'hAAAA, 1'b0);
      send_beat(64'hBBBB, 1'b1);
      total++; if (m_payload !== exp) begin bad++; $display("FAIL partial_payload: got %h want %h", m_payload, exp); end
      total++; if (m_last !== 1'b1)   begin bad++; $display("FAIL partial_last: got %b want 1", m_last); end
      @(posedge clk); #1;
      send_beat(64'h5, 1'b1);
      exp = 256'h5;
      total++; if (m_valid !== 1'b1)  begin bad++; $display("FAIL single_valid: got %b want 1", m_valid); end
      total++; if (m_payload !== exp) begin bad++; $display("FAIL single_stale: got %h want %h", m_payload, exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [63:0]  b [12];
      logic [255:0] e [3];
      for (int i = 0; i < 12; i++) b[i] = 64'h100 + 64'(i);
      for (int j = 0; j < 3; j++) e[j] = {b[4*j+3], b[4*j+2], b[4*j+1], b[4*j]};
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_beat(b[i], 1'b0);
      total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL bp_s_ready: got %b want 0", s_ready); end
      total++; if (m_payload !== e[0]) begin bad++; $display("FAIL bp_hold0: got %h want %h", m_payload, e[0]); end
      repeat (3) @(posedge clk);
      #1;
      total++; if (m_valid !== 1'b1)   begin bad++; $display("FAIL bp_valid_hold: got %b want 1", m_valid); end
      total++; if (m_payload !== e[0]) begin bad++; $display("FAIL bp_stable: got %h want %h", m_payload, e[0]); end
      total++; if (s_ready !== 1'b0)   begin bad++; $display("FAIL bp_s_ready_hold: got %b want 0", s_ready); end
      m_ready = 1'b1;
      fork
         begin
            for (int i = 8; i < 12; i++) send_beat(b[i], i == 11);
         end
         begin
            int idx = 0;
            for (int n = 0; n < 100 && idx < 3; n++) begin
               @(negedge clk);
               if (m_valid) begin
                  total++; if (m_payload !== e[idx]) begin bad++; $display("FAIL bp_order%0d: got %h want %h", idx, m_payload, e[idx]); end
                  total++; if (m_last !== (idx == 2)) begin bad++; $display("FAIL bp_last%0d: got %b want %b", idx, m_last, idx == 2); end
                  idx++;
               end
            end
            total++;
            if (idx != 3) begin bad++; $display("FAIL bp_count: got %0d elements want 3", idx); end
         end
      join
      @(posedge clk); #1;
      total++; if (m_valid !== 1'b0)   begin bad++; $display("FAIL bp_drain: m_valid got %b want 0", m_valid); end
      total++; if (elem_cnt !== 16'd0) begin bad++; $display("FAIL bp_cnt: got %0d want 0", elem_cnt); end
   endtask

   task automatic test_msb_flag();
      m_ready = 1'b1;
      send_beat(64'h0, 1'b0);
      send_beat(64'h0, 1'b0);
      send_beat(64'h0, 1'b0);
      send_beat(64'h8000_0000_0000_0000, 1'b1);
      total++; if (m_payload[255] !== 1'b1) begin bad++; $display("FAIL msb_forward: got %b want 1", m_payload[255]); end
      total++; if (err_msb !== 1'b0)        begin bad++; $display("FAIL msb_early: got %b want 0", err_msb); end
      @(posedge clk); #1;
      total++; if (err_msb !== 1'b1)        begin bad++; $display("FAIL msb_set: got %b want 1", err_msb); end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      total++; if (err_msb !== 1'b0)        begin bad++; $display("FAIL msb_clear: got %b want 0", err_msb); end
      m_ready = 1'b0;
      send_beat(64'h0, 1'b0);
      send_beat(64'h0, 1'b0);
      send_beat(64'h0, 1'b0);
      send_beat(64'h8000_0000_0000_0000, 1'b1);
      err_clr = 1'b1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      total++; if (err_msb !== 1'b1)        begin bad++; $display("FAIL msb_set_wins: got %b want 1", err_msb); end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
   endtask

   task automatic test_multi_element();
      m_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 12; i++) send_beat(64'h200 + 64'(i), i == 11);
         end
         begin
            int idx = 0;
            for (int n = 0; n < 100 && idx < 3; n++) begin
               @(negedge clk);
               if (m_valid) begin
                  total++; if (m_last !== (idx == 2)) begin bad++; $display("FAIL multi_last%0d: got %b want %b", idx, m_last, idx == 2); end
                  @(posedge clk); #1;
                  total++;
                  if (elem_cnt !== ((idx == 2) ? 16'd0 : 16'(idx + 1))) begin
                     bad++; $display("FAIL multi_cnt%0d: got %0d want %0d", idx, elem_cnt, (idx == 2) ? 0 : idx + 1);
                  end
                  idx++;
               end
            end
            total++;
            if (idx != 3) begin bad++; $display("FAIL multi_count: got %0d elements want 3", idx); end
         end
      join
   endtask

   task automatic test_reset_mid();
      logic [255:0] exp;
      bit           extra = 0;
      m_ready = 1'b1;
      send_beat(64'h0, 1'b0);
      send_beat(64'h0, 1'b0);
      send_beat(64'h0, 1'b0);
      send_beat(64'h8000_0000_0000_0001, 1'b0);
      @(posedge clk); #1;
      total++; if (elem_cnt !== 16'd1) begin bad++; $display("FAIL mid_pre_cnt: got %0d want 1", elem_cnt); end
      total++; if (err_msb !== 1'b1)   begin bad++; $display("FAIL mid_pre_err: got %b want 1", err_msb); end
      send_beat(64'hDEAD, 1'b0);
      send_beat(64'hBEEF, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      total++; if (m_valid !== 1'b0)     begin bad++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
      total++; if (m_last !== 1'b0)      begin bad++; $display("FAIL mid_m_last: got %b want 0", m_last); end
      total++; if (m_payload !== 256'h0) begin bad++; $display("FAIL mid_payload: got %h want 0", m_payload); end
      total++; if (err_msb !== 1'b0)     begin bad++; $display("FAIL mid_err: got %b want 0", err_msb); end
      total++; if (elem_cnt !== 16'd0)   begin bad++; $display("FAIL mid_cnt: got %0d want 0", elem_cnt); end
      reset = 1'b1;
      @(posedge clk); #1;
      total++; if (m_valid !== 1'b0)     begin bad++; $display("FAIL mid_quiet: m_valid got %b want 0", m_valid); end
      exp = {64'h44, 64'h33, 64'h22, 64'h11};
      send_beat(64'h11, 1'b0);
      send_beat(64'h22, 1'b0);
      send_beat(64'h33, 1'b0);
      send_beat(64'h44, 1'b1);
      total++; if (m_payload !== exp)  begin bad++; $display("FAIL mid_fresh: got %h want %h", m_payload, exp); end
      total++; if (m_last !== 1'b1)    begin bad++; $display("FAIL mid_fresh_last: got %b want 1", m_last); end
      @(posedge clk); #1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (m_valid) extra = 1;
      end
      total++; if (extra) begin bad++; $display("FAIL mid_extra: got extra element want none"); end
   endtask

   initial begin
      reset   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      err_clr = 1'b0;
      test_reset();
      test_full_element();
      test_partial_element();
      test_backpressure();
      test_msb_flag();
      test_multi_element();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
